tohost_monitor: RTL and testbench



---
 rtl/tohost_monitor_if.sv | 10 +
 rtl/tohost_monitor.sv | 108 ++++++++++
 tb/tb_tohost_monitor.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/tohost_monitor_if.sv
// Data-memory write port as seen by the tohost monitor.
// The core (or bench) drives the master side; the monitor only listens.
interface tohost_monitor_if;
    logic [3:0]  mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] write_data;

    modport master (output mem_write_en, output mem_addr, output write_data);
    modport slave  (input  mem_write_en, input  mem_addr, input  write_data);
endinterface

// File: rtl/tohost_monitor.sv
// Watches dmem stores to the riscv-tests tohost word and reports pass/fail/timeout.
// All status is sticky until reset and comes straight from registers.
module tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter int          TIMEOUT_CYCLES = 1500,
    parameter int          CNT_WIDTH      = 32
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    tohost_monitor_if.slave      bus,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic                 bad_write,
    output logic [30:0]          test_num,
    output logic [31:0]          tohost_value,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] store_count
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_RUN_CYCLE = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE        = CNT_WIDTH'(1);

    state_t                state_q, state_d;
    logic                  bad_write_q, bad_write_d;
    logic [30:0]           test_num_q, test_num_d;
    logic [31:0]           tohost_value_q, tohost_value_d;
    logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;
    logic [CNT_WIDTH-1:0]  store_count_q, store_count_d;

    logic store_ev;
    logic hit;

    assign store_ev = |bus.mem_write_en;
    assign hit      = store_ev && (bus.mem_addr[31:2] == TOHOST_ADDR[31:2]);

    always_comb begin
        state_d        = state_q;
        bad_write_d    = bad_write_q;
        test_num_d     = test_num_q;
        tohost_value_d = tohost_value_q;
        cycle_count_d  = cycle_count_q;
        store_count_d  = store_count_q;

        if (state_q == ST_RUN) begin
            if (cycle_count_q != '1)
                cycle_count_d = cycle_count_q + CNT_ONE;
            if (store_ev && (store_count_q != '1))
                store_count_d = store_count_q + CNT_ONE;

            // Terminal tohost writes are checked before the watchdog so a hit wins a tie.
            if (hit && (bus.mem_write_en != 4'hF)) begin
                state_d     = ST_FAIL;
                bad_write_d = 1'b1;
                test_num_d  = '0;
            end else if (hit && (bus.write_data == 32'd1)) begin
                state_d        = ST_PASS;
                tohost_value_d = bus.write_data;
            end else if (hit && bus.write_data[0]) begin
                state_d        = ST_FAIL;
                test_num_d     = bus.write_data[31:1];
                tohost_value_d = bus.write_data;
            end else begin
                if (hit)
                    tohost_value_d = bus.write_data;
                if (cycle_count_q == LAST_RUN_CYCLE)
                    state_d = ST_TIMEOUT;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q        <= ST_RUN;
            bad_write_q    <= 1'b0;
            test_num_q     <= '0;
            tohost_value_q <= '0;
            cycle_count_q  <= '0;
            store_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            bad_write_q    <= bad_write_d;
            test_num_q     <= test_num_d;
            tohost_value_q <= tohost_value_d;
            cycle_count_q  <= cycle_count_d;
            store_count_q  <= store_count_d;
        end
    end

    assign pass         = (state_q == ST_PASS);
    assign fail         = (state_q == ST_FAIL);
    assign timeout      = (state_q == ST_TIMEOUT);
    assign done         = (state_q != ST_RUN);
    assign bad_write    = bad_write_q;
    assign test_num     = test_num_q;
    assign tohost_value = tohost_value_q;
    assign cycle_count  = cycle_count_q;
    assign store_count  = store_count_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// Bench for tohost_monitor: directed scenarios plus random store streams,
// every cycle compared against an event-level model of the monitor.
module tb_tohost_monitor;
    localparam logic [31:0] TOHOST = 32'h0000_1000;
    localparam int          TO     = 1500;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        done, pass, fail, timeout, bad_write;
    logic [30:0] test_num;
    logic [31:0] tohost_value, cycle_count, store_count;

    tohost_monitor_if bus();

    tohost_monitor #(
        .TOHOST_ADDR   (TOHOST),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (32)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .bus         (bus.slave),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .bad_write   (bad_write),
        .test_num    (test_num),
        .tohost_value(tohost_value),
        .cycle_count (cycle_count),
        .store_count (store_count)
    );

    always #10 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: outcome flags plus counters, updated once per sampled edge.
    bit        m_pass, m_fail, m_to, m_bad;
    bit [30:0] m_tn;
    bit [31:0] m_tv, m_cyc, m_st;

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [191:0] dut_status();
        logic [191:0] r;
        r = '0;
        r[131:0] = {done, pass, fail, timeout, bad_write, test_num,
                    tohost_value, cycle_count, store_count};
        return r;
    endfunction

    function automatic logic [191:0] model_status();
        logic [191:0] r;
        r = '0;
        r[131:0] = {m_pass | m_fail | m_to, m_pass, m_fail, m_to, m_bad, m_tn,
                    m_tv, m_cyc, m_st};
        return r;
    endfunction

    task automatic model_update(input bit rst, input logic [3:0] en,
                                input logic [31:0] addr, input logic [31:0] data);
        bit        finished;
        bit        is_hit;
        bit [31:0] elapsed;
        finished = m_pass || m_fail || m_to;
        if (rst) begin
            {m_pass, m_fail, m_to, m_bad} = '0;
            m_tn = '0; m_tv = '0; m_cyc = '0; m_st = '0;
        end else if (!finished) begin
            elapsed = m_cyc;
            if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            if (en != 0 && m_st != 32'hFFFF_FFFF) m_st = m_st + 1;
            is_hit = (en != 0) && ((addr / 4) == (TOHOST / 4));
            if (is_hit && en != 4'hF) begin
                m_fail = 1; m_bad = 1; m_tn = 0;
            end else if (is_hit && data == 1) begin
                m_pass = 1; m_tv = 1;
            end else if (is_hit && (data % 2 == 1)) begin
                m_fail = 1; m_tn = 31'(data / 2); m_tv = data;
            end else begin
                if (is_hit) m_tv = data;
                if (elapsed == TO - 1) m_to = 1;
            end
        end
    endtask

    task automatic step(input bit rst, input logic [3:0] en,
                        input logic [31:0] addr, input logic [31:0] data);
        @(negedge sys_clk);
        sys_rst_n        = ~rst;
        bus.mem_write_en = en;
        bus.mem_addr     = addr;
        bus.write_data   = data;
        @(posedge sys_clk);
        model_update(rst, en, addr, data);
        #1;
        check_eq("status", dut_status(), model_status());
    endtask

    task automatic do_reset();
        step(1'b1, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 4'h0, $urandom, $urandom);
    endtask

    task automatic store(input logic [3:0] en, input logic [31:0] addr, input logic [31:0] data);
        step(1'b0, en, addr, data);
    endtask

    initial begin
        bus.mem_write_en = '0;
        bus.mem_addr     = '0;
        bus.write_data   = '0;

        // Pass after ten idle cycles; counters frozen afterwards.
        do_reset();
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_cycle", cycle_count, 32'd0);
        check_eq("rst_tohost", tohost_value, 32'd0);
        idle(10);
        store(4'hF, TOHOST, 32'h1);
        check_eq("p1_pass", pass, 1'b1);
        check_eq("p1_done", done, 1'b1);
        check_eq("p1_fail", fail, 1'b0);
        check_eq("p1_testnum", test_num, 31'd0);
        check_eq("p1_tohost", tohost_value, 32'd1);
        check_eq("p1_cycle", cycle_count, 32'd11);
        store(4'hF, TOHOST, 32'h7);
        idle(5);
        check_eq("p1_frozen", cycle_count, 32'd11);
        check_eq("p1_sticky", {pass, fail}, 2'b10);

        // Odd tohost code fails with test number; later pass ignored.
        do_reset();
        store(4'hF, TOHOST, 32'h7);
        check_eq("f_fail", fail, 1'b1);
        check_eq("f_testnum", test_num, 31'd3);
        check_eq("f_tohost", tohost_value, 32'd7);
        store(4'hF, TOHOST, 32'h1);
        check_eq("f_hold", {pass, fail, tohost_value}, {2'b01, 32'd7});

        // Neighbouring word and an even tohost write leave RUN; then watchdog.
        do_reset();
        store(4'hF, TOHOST + 32'd4, 32'h1);
        store(4'hF, TOHOST, 32'h0);
        check_eq("e_done", done, 1'b0);
        check_eq("e_tohost", tohost_value, 32'd0);
        check_eq("e_stores", store_count, 32'd2);
        idle(1500);
        check_eq("e_timeout", timeout, 1'b1);
        check_eq("e_cycle", cycle_count, 32'd1500);

        // Partial write to tohost.
        do_reset();
        store(4'b0001, TOHOST, 32'h1);
        check_eq("b_fail", {fail, bad_write}, 2'b11);
        check_eq("b_testnum", test_num, 31'd0);
        check_eq("b_tohost", tohost_value, 32'd0);

        // Pass on the exact expiry cycle beats the watchdog.
        do_reset();
        idle(1499);
        check_eq("x_pre", cycle_count, 32'd1499);
        store(4'hF, TOHOST + 32'd2, 32'h1);
        check_eq("x_pass", {pass, timeout}, 2'b10);
        check_eq("x_cycle", cycle_count, 32'd1500);

        // Reset from FAIL fully restarts.
        do_reset();
        store(4'hF, TOHOST, 32'h3);
        check_eq("r_fail", fail, 1'b1);
        do_reset();
        check_eq("r_clear", {done, pass, fail, timeout, bad_write, test_num, tohost_value},
                 {5'b0, 31'd0, 32'd0});
        store(4'hF, TOHOST, 32'h1);
        check_eq("r_pass", pass, 1'b1);

        // Random store streams.
        for (int ep = 0; ep < 12; ep++) begin
            int post;
            post = 0;
            do_reset();
            for (int c = 0; c < 1700 && post < 4; c++) begin
                logic [3:0]  en;
                logic [31:0] addr, data;
                int r, k;
                if (ep % 4 == 1 && c == 40) begin
                    do_reset();
                    continue;
                end
                en = ($urandom_range(0, 99) < 65) ? 4'h0 :
                     ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(1, 15));
                r = $urandom_range(0, 9);
                addr = (r < 3) ? (TOHOST | 32'($urandom_range(0, 3))) :
                       (r < 5) ? TOHOST + 32'd4 :
                       (r < 6) ? TOHOST - 32'd4 : $urandom;
                k = $urandom_range(0, 9);
                data = (k == 0) ? 32'h1 : (k == 1) ? ($urandom | 32'h1) : ($urandom & ~32'h1);
                if (ep % 3 == 0) begin
                    if (en != 0) en = 4'hF;
                    data = data & ~32'h1;
                end
                step(1'b0, en, addr, data);
                if (m_pass || m_fail || m_to) post++;
            end
            check_eq("ep_done", done, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
